cache_plru_tree: RTL and testbench

- Parametrised tree pseudo-LRU replacement controller for an N-way set-associative cache. It keeps NUM_WAYS-1 tree bits per set.
- Separate access-update and victim-request channels. Victim output is registered.
- Invalid-way priority: an invalid way is always chosen before the tree victim.
- Multi-cycle flush sequencer re-initialises every set.
- Sits beside the tag/valid arrays in the cache controller. It generalises the fixed 8-way pLRU.

---
 rtl/cache_plru_tree_if.sv | 33 +++
 rtl/cache_plru_tree.sv | 137 +++++++++++++
 tb/tb_cache_plru_tree.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cache_plru_tree_if.sv
// Access-update, victim-request and flush signals between cache controller and pLRU.
// The master modport is the cache controller; the slave modport is the replacement block.
interface cache_plru_tree_if #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 64
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    logic                flush_i;
    logic                busy_o;
    logic                upd_valid_i;
    logic [SET_W-1:0]    upd_set_i;
    logic [WAY_W-1:0]    upd_way_i;
    logic                vic_req_i;
    logic [SET_W-1:0]    vic_set_i;
    logic [NUM_WAYS-1:0] way_valid_i;
    logic                vic_valid_o;
    logic [WAY_W-1:0]    vic_way_o;
    logic [31:0]         upd_cnt_o;
    logic [31:0]         vic_tree_cnt_o;
    logic [31:0]         vic_inv_cnt_o;

    modport master (
        output flush_i, upd_valid_i, upd_set_i, upd_way_i, vic_req_i, vic_set_i, way_valid_i,
        input  busy_o, vic_valid_o, vic_way_o, upd_cnt_o, vic_tree_cnt_o, vic_inv_cnt_o
    );

    modport slave (
        input  flush_i, upd_valid_i, upd_set_i, upd_way_i, vic_req_i, vic_set_i, way_valid_i,
        output busy_o, vic_valid_o, vic_way_o, upd_cnt_o, vic_tree_cnt_o, vic_inv_cnt_o
    );
endinterface

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU for an N-way cache; victim registered (1 cycle), updates visible next cycle.
// Flush blocks updates/victims for NUM_SETS cycles (busy_o); PLRU_PERF_EN adds perf counters.
module cache_plru_tree #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 64,
    parameter int WAY_W    = $clog2(NUM_WAYS),
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cache_plru_tree_if.slave  bus
);
    localparam int NODES  = NUM_WAYS - 1;
    localparam int NODE_W = (WAY_W > 1) ? WAY_W : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [SET_W-1:0]               fcnt_q;
    logic                           busy;
    logic                           flush_start;
    logic                           upd_acc, vic_acc;
    logic [NUM_SETS-1:0][NODES-1:0] tree_q;
    logic [NODES-1:0]               upd_mask, upd_bits, vic_row;
    logic [WAY_W-1:0]               tree_way, inv_way;
    logic                           inv_hit;
    logic                           vic_valid_q;
    logic [WAY_W-1:0]               vic_way_q;
    int unsigned                    unode, vnode;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.flush_i) state_d = FLUSH;
            FLUSH:   if (fcnt_q == SET_W'(NUM_SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == FLUSH);
        flush_start = (state_q == IDLE) && bus.flush_i;
    end

    // Counter sits at 0 in IDLE, so entering FLUSH always starts at set 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      fcnt_q <= '0;
        else if (!busy)   fcnt_q <= '0;
        else              fcnt_q <= fcnt_q + SET_W'(1);
    end

    assign upd_acc = bus.upd_valid_i & ~busy;
    assign vic_acc = bus.vic_req_i & ~busy;

    always_comb begin
        upd_mask = '0;
        upd_bits = '0;
        unode    = 0;
        for (int l = 0; l < WAY_W; l++) begin
            upd_mask[unode[NODE_W-1:0]] = 1'b1;
            upd_bits[unode[NODE_W-1:0]] = bus.upd_way_i[WAY_W-1-l];
            unode = 2 * unode + 1 + 32'(bus.upd_way_i[WAY_W-1-l]);
        end
    end

    // Walk away from the most recently used half at every level.
    always_comb begin
        vic_row  = tree_q[bus.vic_set_i];
        tree_way = '0;
        vnode    = 0;
        for (int l = 0; l < WAY_W; l++) begin
            tree_way[WAY_W-1-l] = ~vic_row[vnode[NODE_W-1:0]];
            vnode = 2 * vnode + 1 + 32'(tree_way[WAY_W-1-l]);
        end
    end

    always_comb begin
        inv_hit = ~&bus.way_valid_i;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!bus.way_valid_i[i]) inv_way = i[WAY_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tree_q <= '1;
        end else if (busy) begin
            tree_q[fcnt_q] <= '1;
        end else if (upd_acc) begin
            tree_q[bus.upd_set_i] <= (tree_q[bus.upd_set_i] & ~upd_mask) | (upd_bits & upd_mask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
        end else begin
            vic_valid_q <= vic_acc;
            if (vic_acc) vic_way_q <= inv_hit ? inv_way : tree_way;
        end
    end

    assign bus.busy_o      = busy;
    assign bus.vic_valid_o = vic_valid_q;
    assign bus.vic_way_o   = vic_way_q;

`ifdef PLRU_PERF_EN
    logic [31:0] upd_cnt_q, vic_tree_cnt_q, vic_inv_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || flush_start) begin
            upd_cnt_q      <= '0;
            vic_tree_cnt_q <= '0;
            vic_inv_cnt_q  <= '0;
        end else begin
            if (upd_acc && upd_cnt_q != '1)                   upd_cnt_q      <= upd_cnt_q + 32'd1;
            if (vic_acc && !inv_hit && vic_tree_cnt_q != '1) vic_tree_cnt_q <= vic_tree_cnt_q + 32'd1;
            if (vic_acc && inv_hit && vic_inv_cnt_q != '1)   vic_inv_cnt_q  <= vic_inv_cnt_q + 32'd1;
        end
    end

    assign bus.upd_cnt_o      = upd_cnt_q;
    assign bus.vic_tree_cnt_o = vic_tree_cnt_q;
    assign bus.vic_inv_cnt_o  = vic_inv_cnt_q;
`else
    assign bus.upd_cnt_o      = 32'd0;
    assign bus.vic_tree_cnt_o = 32'd0;
    assign bus.vic_inv_cnt_o  = 32'd0;
`endif
endmodule

// File: tb/tb_cache_plru_tree.sv
// Scoreboard bench for cache_plru_tree: expected victims queued at request, popped on vic_valid_o.
module tb_cache_plru_tree;
    localparam int NW = 8;
    localparam int NS = 64;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   exp_q[$];
    int   busy_cnt;
    int   vld_seen;

    cache_plru_tree_if #(.NUM_WAYS(NW), .NUM_SETS(NS)) bus ();

    cache_plru_tree #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.vic_valid_o) begin
            if (exp_q.size() == 0) chk("vic_spurious", 32'd1, 32'd0);
            else                   chk("vic_way", 32'(bus.vic_way_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vic(input int set, input logic [NW-1:0] vld, input int exp);
        bus.vic_req_i   = 1'b1;
        bus.vic_set_i   = set[5:0];
        bus.way_valid_i = vld;
        exp_q.push_back(exp);
        tick();
        bus.vic_req_i   = 1'b0;
    endtask

    task automatic upd(input int set, input int way);
        bus.upd_valid_i = 1'b1;
        bus.upd_set_i   = set[5:0];
        bus.upd_way_i   = way[2:0];
        tick();
        bus.upd_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0;
        bus.flush_i = 1'b0; bus.upd_valid_i = 1'b0; bus.upd_set_i = '0; bus.upd_way_i = '0;
        bus.vic_req_i = 1'b0; bus.vic_set_i = '0; bus.way_valid_i = '1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_vld", 32'(bus.vic_valid_o), 0);
        chk("rst_way", 32'(bus.vic_way_o), 0);
        chk("rst_upd_cnt", bus.upd_cnt_o, 0);
        chk("rst_tree_cnt", bus.vic_tree_cnt_o, 0);
        chk("rst_inv_cnt", bus.vic_inv_cnt_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Reset tree points everywhere to 1, so the walk lands on way 0.
        vic(5, 8'hFF, 0);
        @(negedge clk); chk("vld_pulse_hi", 32'(bus.vic_valid_o), 1);
        @(negedge clk); chk("vld_pulse_lo", 32'(bus.vic_valid_o), 0);
        chk("way_hold", 32'(bus.vic_way_o), 0);
        #1;

        upd(3, 0);
        vic(3, 8'hFF, 4);

        upd(7, 0); upd(7, 4); upd(7, 2); upd(7, 6);
        vic(7, 8'hFF, 1);
        vic(6, 8'hFF, 0);

        vic(7, 8'b1111_0111, 3);
        vic(7, 8'hFF, 1);

        bus.upd_valid_i = 1'b1; bus.upd_set_i = 6'd2; bus.upd_way_i = 3'd0;
        vic(2, 8'hFF, 0);
        bus.upd_valid_i = 1'b0;
        vic(2, 8'hFF, 4);
        tick();

`ifdef PLRU_PERF_EN
        chk("pre_upd_cnt", bus.upd_cnt_o, 6);
        chk("pre_tree_cnt", bus.vic_tree_cnt_o, 7);
        chk("pre_inv_cnt", bus.vic_inv_cnt_o, 1);
`endif

        // Flush with a request held across it and a dropped update to an already-flushed set.
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        bus.vic_req_i = 1'b1; bus.vic_set_i = 6'd0; bus.way_valid_i = 8'hFF;
        exp_q.push_back(0);
        busy_cnt = 0; vld_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
            busy_cnt++;
            if (bus.vic_valid_o) vld_seen++;
            if (busy_cnt == 2) begin
                chk("flush_upd_cnt", bus.upd_cnt_o, 0);
                chk("flush_tree_cnt", bus.vic_tree_cnt_o, 0);
                chk("flush_inv_cnt", bus.vic_inv_cnt_o, 0);
            end
            if (busy_cnt == 5) begin
                bus.upd_valid_i = 1'b1; bus.upd_set_i = 6'd0; bus.upd_way_i = 3'd0;
            end
            if (busy_cnt == 6) bus.upd_valid_i = 1'b0;
        end
        chk("busy_len", busy_cnt, NS);
        chk("vld_during_busy", vld_seen, 0);
        @(posedge clk); #1 bus.vic_req_i = 1'b0;
        @(negedge clk); chk("held_served", 32'(bus.vic_valid_o), 1);
        #1;

        for (int s = 0; s < NS; s++) vic(s, 8'hFF, 0);
        tick();
`ifdef PLRU_PERF_EN
        chk("post_tree_cnt", bus.vic_tree_cnt_o, 32'(NS + 1));
        chk("post_upd_cnt", bus.upd_cnt_o, 0);
`endif

        // Reset in the middle of a flush returns straight to idle.
        upd(9, 0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        repeat (5) tick();
        chk("mid_flush_busy", 32'(bus.busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        vic(9, 8'hFF, 0);

        repeat (4) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
